// File: rtl/core_dmem_responder.sv
// ---------------------------------------------------------------------------
// core_dmem_responder
//
// Responder end of the core data memory interface. It grants an execute-stage
// request after a programmable number of wait states. It then performs a
// byte-strobed write or a 64-bit read on an internal word array. The response
// (rdata, err) is registered and presented on the cycle after grant.
//
// Handshake: dmem_req is held by the requester until dmem_gnt is seen high in
// the same cycle. A transfer happens on every cycle where req && gnt. The
// response registers change only on such a cycle and hold otherwise.
//
// Ports:
//   g_clk, g_reset     clock, synchronous active-high reset
//   dmem_req           request valid (held until granted)
//   dmem_addr          request byte address (AW bits)
//   dmem_wen           1 = write, 0 = read
//   dmem_strb          byte write strobes (DW/8 bits)
//   dmem_wdata         write data
//   dmem_gnt           request accepted this cycle (combinational)
//   dmem_err           response error, valid from the cycle after grant
//   dmem_rdata         read data, valid from the cycle after grant
//   stall_cycles       wait states inserted before each grant
//   cnt_rd/wr/err      granted good reads / good writes / erroring accesses
// ---------------------------------------------------------------------------
module core_dmem_responder #(
    parameter int AW = 39,
    parameter int DW = 64,
    parameter int DEPTH = 1024,
    parameter logic [AW-1:0] BASE = 39'h00_1000_0000,
    parameter int CW = 32
) (
    input  logic          g_clk,
    input  logic          g_reset,
    input  logic          dmem_req,
    input  logic [AW-1:0] dmem_addr,
    input  logic          dmem_wen,
    input  logic [DW/8-1:0] dmem_strb,
    input  logic [DW-1:0] dmem_wdata,
    output logic          dmem_gnt,
    output logic          dmem_err,
    output logic [DW-1:0] dmem_rdata,
    input  logic [3:0]    stall_cycles,
    output logic [CW-1:0] cnt_rd,
    output logic [CW-1:0] cnt_wr,
    output logic [CW-1:0] cnt_err
);

    localparam int SW = DW / 8;
    localparam int IW = $clog2(DEPTH);
    // One past the last valid byte address; one extra bit so it cannot wrap.
    localparam logic [AW:0] LIMIT = (AW+1)'(BASE) + (AW+1)'(DEPTH * 8);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Wait counter doubles as the handshake state:
    // 0 = IDLE, non-zero while req && !gnt = WAIT, gnt high = GRANT.
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] cnt_rd_q, cnt_rd_d;
    logic [CW-1:0] cnt_wr_q, cnt_wr_d;
    logic [CW-1:0] cnt_err_q, cnt_err_d;

    logic [DW-1:0] mem_q [DEPTH];

    logic          in_range;
    logic          acc_err;
    logic          do_write;
    logic [AW-1:0] offset;
    logic [IW-1:0] idx;
    logic          unused_addr_bits;

    // Address decode. addr[2:0] is not used for indexing; lane shifting
    // belongs to the writeback stage.
    always_comb begin
        offset   = dmem_addr - BASE;
        idx      = offset[IW+2:3];
        in_range = ({1'b0, dmem_addr} >= {1'b0, BASE}) && ({1'b0, dmem_addr} < LIMIT);
        acc_err  = !in_range || (dmem_wen && (dmem_strb == '0));
    end

    assign unused_addr_bits = ^{offset[AW-1:IW+3], offset[2:0]};

    // State register and response/statistics registers.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            cnt_rd_q   <= '0;
            cnt_wr_q   <= '0;
            cnt_err_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            cnt_rd_q   <= cnt_rd_d;
            cnt_wr_q   <= cnt_wr_d;
            cnt_err_q  <= cnt_err_d;
        end
    end

    // Next-state: count while a request waits, saturating at 15. Any grant or
    // a dropped request returns to IDLE so the next attempt waits in full.
    always_comb begin
        wait_cnt_d = '0;
        if (dmem_req && !dmem_gnt) begin
            wait_cnt_d = (wait_cnt_q == 4'hF) ? 4'hF : wait_cnt_q + 4'd1;
        end
    end

    // Outputs: grant compares against the live stall_cycles value, so a
    // change mid-wait takes effect immediately.
    always_comb begin
        dmem_gnt  = dmem_req && (wait_cnt_q >= stall_cycles);
        err_d     = err_q;
        rdata_d   = rdata_q;
        cnt_rd_d  = cnt_rd_q;
        cnt_wr_d  = cnt_wr_q;
        cnt_err_d = cnt_err_q;
        do_write  = 1'b0;
        if (dmem_gnt) begin
            if (acc_err) begin
                err_d     = 1'b1;
                rdata_d   = '0;
                cnt_err_d = cnt_err_q + CNT_ONE;
            end else if (dmem_wen) begin
                do_write  = 1'b1;
                err_d     = 1'b0;
                rdata_d   = '0;
                cnt_wr_d  = cnt_wr_q + CNT_ONE;
            end else begin
                err_d     = 1'b0;
                rdata_d   = mem_q[idx];
                cnt_rd_d  = cnt_rd_q + CNT_ONE;
            end
        end
    end

    // Array is not reset, but a grant coinciding with reset must not write.
    always_ff @(posedge g_clk) begin
        if (do_write && !g_reset) begin
            for (int b = 0; b < SW; b++) begin
                if (dmem_strb[b]) begin
                    mem_q[idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign dmem_err   = err_q;
    assign dmem_rdata = rdata_q;
    assign cnt_rd     = cnt_rd_q;
    assign cnt_wr     = cnt_wr_q;
    assign cnt_err    = cnt_err_q;

endmodule

// File: tb/tb_core_dmem_responder.sv
module tb_core_dmem_responder;

    localparam int DEPTH = 1024;
    localparam longint BASE_L = 64'h1000_0000;
    localparam logic [38:0] BASE_A = 39'h00_1000_0000;

    // clock / reset
    logic g_clk = 1'b0;
    logic g_reset;
    always #5 g_clk = ~g_clk;

    logic        dmem_req;
    logic [38:0] dmem_addr;
    logic        dmem_wen;
    logic [7:0]  dmem_strb;
    logic [63:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_err;
    logic [63:0] dmem_rdata;
    logic [3:0]  stall_cycles;
    logic [31:0] cnt_rd, cnt_wr, cnt_err;

    core_dmem_responder dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
        .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
        .stall_cycles(stall_cycles),
        .cnt_rd(cnt_rd), .cnt_wr(cnt_wr), .cnt_err(cnt_err)
    );

    int errors = 0;
    int checks = 0;

    // reference model: sparse word array plus expected response/statistics
    logic [63:0] ref_mem [int];
    logic [63:0] exp_rdata;
    logic        exp_e;
    logic [31:0] exp_rd, exp_wr, exp_err;

    function automatic void model_reset();
        exp_rdata = '0; exp_e = 1'b0;
        exp_rd = '0; exp_wr = '0; exp_err = '0;
    endfunction

    function automatic void model_access(longint a, bit wen, logic [7:0] strb, logic [63:0] wd);
        bit inr;
        int w;
        logic [63:0] word;
        inr = (a >= BASE_L) && (a < BASE_L + longint'(DEPTH) * 8);
        w = int'((a - BASE_L) / 8);
        if (!inr || (wen && strb == 8'h00)) begin
            exp_e = 1'b1; exp_rdata = '0; exp_err++;
        end else if (wen) begin
            word = ref_mem.exists(w) ? ref_mem[w] : 64'h0;
            for (int b = 0; b < 8; b++)
                if (strb[b]) word[8*b +: 8] = wd[8*b +: 8];
            ref_mem[w] = word;
            exp_e = 1'b0; exp_rdata = '0; exp_wr++;
        end else begin
            exp_e = 1'b0; exp_rdata = ref_mem[w]; exp_rd++;
        end
    endfunction

    // driver: holds req until grant (bounded), returns wait cycles seen and
    // whether the response stayed stable while waiting. waits = -1 on timeout.
    task automatic access(input logic [38:0] a, input bit wen, input logic [7:0] strb,
                          input logic [63:0] wd, output int waits, output bit hold_ok);
        logic [63:0] r0;
        logic e0;
        r0 = dmem_rdata; e0 = dmem_err;
        hold_ok = 1'b1; waits = 0;
        dmem_req = 1'b1; dmem_addr = a; dmem_wen = wen; dmem_strb = strb; dmem_wdata = wd;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (dmem_gnt) begin
                @(posedge g_clk); #1;
                dmem_req = 1'b0;
                model_access(longint'(a), wen, strb, wd);
                return;
            end
            waits++;
            if (dmem_rdata !== r0 || dmem_err !== e0) hold_ok = 1'b0;
            @(posedge g_clk); #1;
        end
        dmem_req = 1'b0;
        waits = -1;
    endtask

    task automatic idle(input int n);
        dmem_req = 1'b0;
        repeat (n) @(posedge g_clk);
        #1;
    endtask

    task automatic test_reset();
        g_reset = 1'b1; dmem_req = 1'b0; stall_cycles = 4'd0;
        dmem_addr = 39'($urandom); dmem_wen = 1'b0; dmem_strb = 8'hFF; dmem_wdata = '0;
        repeat (3) @(posedge g_clk);
        #1 g_reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({dmem_gnt, dmem_err, dmem_rdata, cnt_rd, cnt_wr, cnt_err} !== '0) begin
            errors++;
            $display("FAIL reset: gnt=%b err=%b rdata=%h rd=%0d wr=%0d er=%0d required all 0",
                     dmem_gnt, dmem_err, dmem_rdata, cnt_rd, cnt_wr, cnt_err);
        end
    endtask

    task automatic test_write_read();
        int w1, w2; bit h1, h2;
        stall_cycles = 4'd0;
        access(BASE_A + 39'd8, 1'b1, 8'hFF, 64'h1122334455667788, w1, h1);
        access(BASE_A + 39'd8, 1'b0, 8'h00, 64'h0, w2, h2);
        checks++;
        if (w1 !== 0 || w2 !== 0) begin
            errors++; $display("FAIL b2b_gnt: waits=%0d,%0d required 0,0", w1, w2);
        end
        checks++;
        if ({dmem_rdata, dmem_err, cnt_rd, cnt_wr} !== {64'h1122334455667788, 1'b0, 32'd1, 32'd1}) begin
            errors++; $display("FAIL raw_read: rdata=%h err=%b rd=%0d wr=%0d required 1122334455667788 0 1 1",
                                dmem_rdata, dmem_err, cnt_rd, cnt_wr);
        end
    endtask

    task automatic test_stall();
        int w; bit h;
        stall_cycles = 4'd3;
        for (int k = 0; k < 2; k++) begin
            access(BASE_A + 39'd8, 1'b0, 8'h00, 64'h0, w, h);
            checks++;
            if (w !== 3 || !h) begin
                errors++; $display("FAIL stall3_%0d: waits=%0d hold=%b required 3 1", k, w, h);
            end
            checks++;
            if ({dmem_rdata, dmem_err} !== {exp_rdata, exp_e}) begin
                errors++; $display("FAIL stall3_data_%0d: rdata=%h required %h", k, dmem_rdata, exp_rdata);
            end
        end
    endtask

    task automatic test_partial_write();
        int w; bit h;
        stall_cycles = 4'd0;
        access(BASE_A + 39'd16, 1'b1, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, w, h);
        access(BASE_A + 39'd16, 1'b1, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, w, h);
        access(BASE_A + 39'd21, 1'b0, 8'h00, 64'h0, w, h);
        checks++;
        if (dmem_rdata !== 64'hFFFFFFFF_BBBBBBBB || dmem_err !== 1'b0) begin
            errors++; $display("FAIL partial: rdata=%h err=%b required ffffffffbbbbbbbb 0", dmem_rdata, dmem_err);
        end
    endtask

    task automatic test_out_of_range();
        int w; bit h;
        logic [31:0] e0;
        e0 = cnt_err;
        stall_cycles = 4'd1;
        access(BASE_A + 39'(DEPTH * 8), 1'b0, 8'h00, 64'h0, w, h);
        checks++;
        if ({dmem_err, dmem_rdata} !== {1'b1, 64'h0} || w !== 1) begin
            errors++; $display("FAIL oor_read: err=%b rdata=%h waits=%0d required 1 0 1", dmem_err, dmem_rdata, w);
        end
        access(BASE_A - 39'd8, 1'b1, 8'hFF, 64'hDEAD_BEEF_0000_0000, w, h);
        checks++;
        if ({dmem_err, dmem_rdata} !== {1'b1, 64'h0} || cnt_err !== e0 + 32'd2) begin
            errors++; $display("FAIL oor_write: err=%b rdata=%h cnt_err=%0d required 1 0 %0d",
                                dmem_err, dmem_rdata, cnt_err, e0 + 32'd2);
        end
        // zero-strobe write to a valid word must also error and not modify it
        access(BASE_A + 39'd16, 1'b1, 8'h00, 64'h0, w, h);
        checks++;
        if (dmem_err !== 1'b1 || cnt_err !== exp_err) begin
            errors++; $display("FAIL zero_strb: err=%b cnt_err=%0d required 1 %0d", dmem_err, cnt_err, exp_err);
        end
        stall_cycles = 4'd0;
        access(BASE_A + 39'd16, 1'b0, 8'h00, 64'h0, w, h);
        checks++;
        if (dmem_rdata !== exp_rdata || dmem_err !== 1'b0) begin
            errors++; $display("FAIL err_no_write: rdata=%h required %h", dmem_rdata, exp_rdata);
        end
    endtask

    task automatic test_abandon();
        int w; bit h; bit seen;
        stall_cycles = 4'd5;
        seen = 1'b0;
        dmem_req = 1'b1; dmem_addr = BASE_A + 39'd8; dmem_wen = 1'b0;
        repeat (2) begin
            #1 if (dmem_gnt) seen = 1'b1;
            @(posedge g_clk); #1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL abandon_gnt: gnt=1 required 0");
        end
        idle(1);
        access(BASE_A + 39'd8, 1'b0, 8'h00, 64'h0, w, h);
        checks++;
        if (w !== 5 || !h || dmem_rdata !== exp_rdata) begin
            errors++; $display("FAIL abandon_retry: waits=%0d rdata=%h required 5 %h", w, dmem_rdata, exp_rdata);
        end
    endtask

    task automatic test_random();
        int w; bit h;
        int n_words[9] = '{0, 1, 2, 3, 4, 5, 6, 7, DEPTH - 1};
        logic [38:0] a;
        bit wen;
        logic [7:0] strb;
        logic [63:0] wd;
        int bad;
        stall_cycles = 4'd0;
        foreach (n_words[i])
            access(BASE_A + 39'(n_words[i] * 8), 1'b1, 8'hFF, {$urandom, $urandom}, w, h);
        bad = 0;
        for (int it = 0; it < 200; it++) begin
            stall_cycles = 4'($urandom_range(0, 3));
            a = BASE_A + 39'(n_words[$urandom_range(0, 8)] * 8) + 39'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0: a = BASE_A - 39'($urandom_range(1, 64));
                1: a = BASE_A + 39'(DEPTH * 8) + 39'($urandom_range(0, 64));
                default: ;
            endcase
            wen = 1'($urandom_range(0, 1));
            strb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            wd = {$urandom, $urandom};
            access(a, wen, strb, wd, w, h);
            checks++;
            if (w !== int'(stall_cycles) || !h ||
                {dmem_rdata, dmem_err, cnt_rd, cnt_wr, cnt_err} !== {exp_rdata, exp_e, exp_rd, exp_wr, exp_err}) begin
                errors++;
                if (bad < 10)
                    $display("FAIL rand_%0d: waits=%0d hold=%b rdata=%h err=%b cnt=%0d/%0d/%0d required %0d 1 %h %b %0d/%0d/%0d",
                             it, w, h, dmem_rdata, dmem_err, cnt_rd, cnt_wr, cnt_err,
                             stall_cycles, exp_rdata, exp_e, exp_rd, exp_wr, exp_err);
                bad++;
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
    endtask

    task automatic test_reset_mid();
        int w; bit h; bit g;
        stall_cycles = 4'd0;
        access(BASE_A, 1'b1, 8'hFF, 64'h5A5A5A5A_5A5A5A5A, w, h);
        dmem_req = 1'b1; dmem_addr = BASE_A; dmem_wen = 1'b1; dmem_strb = 8'hFF;
        dmem_wdata = 64'h0123_4567_89AB_CDEF; g_reset = 1'b1;
        #1 g = dmem_gnt;
        @(posedge g_clk); #1;
        dmem_req = 1'b0; g_reset = 1'b0;
        model_reset();
        checks++;
        if (g !== 1'b1 || {dmem_err, dmem_rdata, cnt_rd, cnt_wr, cnt_err} !== '0) begin
            errors++; $display("FAIL reset_mid: gnt=%b err=%b rdata=%h rd=%0d wr=%0d er=%0d required 1 and all 0",
                                g, dmem_err, dmem_rdata, cnt_rd, cnt_wr, cnt_err);
        end
        access(BASE_A, 1'b0, 8'h00, 64'h0, w, h);
        checks++;
        if (dmem_rdata !== 64'h5A5A5A5A_5A5A5A5A || cnt_rd !== 32'd1) begin
            errors++; $display("FAIL reset_no_write: rdata=%h rd=%0d required 5a5a5a5a5a5a5a5a 1", dmem_rdata, cnt_rd);
        end
    endtask

    initial begin
        g_reset = 1'b1; dmem_req = 1'b0; dmem_addr = '0; dmem_wen = 1'b0;
        dmem_strb = '0; dmem_wdata = '0; stall_cycles = '0;
        @(posedge g_clk); #1;
        test_reset();
        test_write_read();
        test_stall();
        test_partial_write();
        test_out_of_range();
        test_abandon();
        test_random();
        test_reset_mid();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_dmem_responder.md
Name: core_dmem_responder

Overview:
Responder end of the core data memory interface. Accepts requests issued by the execute stage, applies a programmable number of wait states, and performs byte-strobed writes or 64-bit reads on an internal word array. It returns read data and an error flag that the writeback stage consumes on the cycle after grant. Used as the tightly coupled data RAM in simulation and FPGA builds, and as the stall and error source for pipeline verification.

Parameters:
AW, 39, memory address width (bits).
DW, 64, data width. Fixed at 64; strobe width is DW/8.
DEPTH, 1024, number of DW-bit words in the array.
BASE, 'h0000_1000_0000 (AW bits), byte address of word 0.
CW, 32, width of the access statistics counters.

Ports:
g_clk  in  1  global clock
g_reset  in  1  synchronous active-high reset
dmem_req  in  1  request valid; held until granted
dmem_addr  in  AW  request byte address
dmem_wen  in  1  1 = write, 0 = read
dmem_strb  in  DW/8  byte write strobes
dmem_wdata  in  DW  write data
dmem_gnt  out  1  request accepted this cycle
dmem_err  out  1  response error; valid from the cycle after grant
dmem_rdata  out  DW  read response data; valid from the cycle after grant
stall_cycles  in  4  wait states to insert before each grant
cnt_rd  out  CW  number of granted, non-erroring reads
cnt_wr  out  CW  number of granted, non-erroring writes
cnt_err  out  CW  number of granted erroring accesses

Behaviour:
- Clocking and reset: one clock domain, g_clk. Reset is synchronous and active-high on g_reset. In reset, wait_cnt, dmem_err, dmem_rdata and all cnt_* clear to 0. Array contents are not reset.
- Grant: dmem_gnt = dmem_req && (wait_cnt >= stall_cycles). This is combinational, so stall_cycles = 0 gives a same-cycle grant. An accepted request is dmem_req && dmem_gnt.
- Wait counter: 4-bit.
  - On req && !gnt: increment, saturating at 15.
  - On gnt, or when !req: clear to 0.
  - If req drops mid-wait, no access occurs and the counter clears.
  - If stall_cycles changes mid-wait, the >= compare applies to the new value immediately.
- States:
  - IDLE: wait_cnt = 0.
  - WAIT: req && wait_cnt < stall_cycles.
  - GRANT: a single cycle with gnt high; returns to IDLE, or back-to-back grants when stall_cycles = 0.
- Address decode:
  - In range iff BASE <= addr < BASE + DEPTH*8.
  - Word index = (addr - BASE) >> 3.
  - addr[2:0] is ignored for indexing; the writeback stage performs lane shifting.
- Error: an access is erroring if the address is out of range, or if it is a write with strb == 0.
  - An erroring access never modifies the array.
  - dmem_err <= 1 and dmem_rdata <= 0 at the next edge.
- Accepted read, no error: dmem_rdata <= mem[idx] and dmem_err <= 0 at the next edge. Latency is 1 cycle from grant.
- Accepted write, no error: for each byte b with strb[b] = 1, mem[idx][8b+7:8b] <= wdata byte b at the next edge. dmem_rdata <= 0 and dmem_err <= 0.
- Response hold: dmem_rdata and dmem_err hold their values until the next accepted request, and do not change during wait states.
- Read-after-write: a read granted on the cycle immediately after a write to the same word returns the new data. The write completes at the edge ending the write's grant cycle.
- Statistics counters: exactly one of cnt_rd, cnt_wr or cnt_err increments at the edge following each accepted request. The counters wrap modulo 2^CW.
- Reset mid-operation: a grant in the same cycle as g_reset is discarded. No array write occurs, and all outputs clear.

Test Plan:
1. stall_cycles = 0, write addr = BASE+8, strb = 'hFF, wdata = 'h1122334455667788, then read addr = BASE+8 on the next cycle. Required: gnt is high on both request cycles; on the cycle after the read grant, dmem_rdata = 'h1122334455667788, dmem_err = 0, cnt_wr = 1, cnt_rd = 1.
2. stall_cycles = 3, read held for 4 cycles. Required: gnt is low for 3 cycles and high on the 4th; rdata updates exactly one cycle later; wait_cnt is 0 afterwards.
3. Partial write: strb = 'h0F, wdata = 'hAAAAAAAA_BBBBBBBB over an existing word 'hFFFFFFFF_FFFFFFFF, then read. Required: rdata = 'hFFFFFFFF_BBBBBBBB.
4. Out-of-range accesses: read at addr = BASE + DEPTH*8, and write at BASE-8. Required: each gives dmem_err = 1 and rdata = 0 the cycle after grant; the array is unchanged; cnt_err = 2.
5. stall_cycles = 5; req is high for 2 cycles then dropped, then reasserted. Required: no grant during the first attempt; on reassertion a full 5 wait cycles are counted again before gnt.
6. g_reset is asserted on a write grant cycle to word 0 (previously 'h5A5A...). Required: word 0 is still 'h5A5A... when read after reset; err, rdata and all counters are 0 immediately after reset.
